wb_stage: RTL and testbench
===========================

# wb_stage

Parametrised writeback stage for the pipelined RV32 core. It combines the MEM/WB pipeline register, an N-way writeback-source select, and a load-data path. The load path waits on a memory response handshake, aligns the returned data and sign- or zero-extends it. Outputs are a registered register-file write port and a bypass/stall interface for the hazard unit.

## Interface
Parameters:
- XLEN, 32: datapath width; must be ≥ 32.
- NSRC, 4: number of writeback candidate sources; must be ≥ 2.
- SEL_W, $clog2(NSRC): width of the source select.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- in_valid  in  1  MEM stage presents an instruction.
- in_ready  out  1  stage can accept; low only in WAIT_MEM.
- in_src  in  NSRC*XLEN  packed candidates; source k is in_src[k*XLEN +: XLEN].
- in_sel  in  SEL_W  source select; ignored when in_is_load=1.
- in_rd  in  5  destination register.
- in_rf_we  in  1  instruction writes the register file.
- in_is_load  in  1  result comes from data memory.
- in_funct3  in  3  load size/sign.
- in_addr_lo  in  2  byte offset of the load address.
- flush  in  1  squash the instruction offered this cycle.
- mem_rvalid  in  1  load data valid.
- mem_rdata  in  XLEN  raw word from data memory.
- rf_we  out  1  register-file write enable.
- rf_wa  out  5  write address.
- rf_wd  out  XLEN  write data.
- load_pending  out  1  high in WAIT_MEM.
- pend_rd  out  5  destination of the pending load.

## Operation
- Accept condition: in_valid && in_ready && !flush. When flush is high, nothing is latched and the state does not change.
- States:
  - EMPTY: no instruction held.
  - WRITE: one cycle; the held instruction is presented on the rf_* outputs.
  - WAIT_MEM: a load is waiting for mem_rvalid.
- Transitions:
  - EMPTY or WRITE, non-load accepted → WRITE.
  - EMPTY or WRITE, load accepted → WAIT_MEM.
  - EMPTY or WRITE, no accept → EMPTY.
  - WAIT_MEM, mem_rvalid → WRITE, with the aligned data registered.
  - WAIT_MEM, no mem_rvalid → WAIT_MEM.
- Write data:
  - Non-load: rf_wd = in_src slice at in_sel, registered at accept.
  - If in_sel ≥ NSRC, the value is 0.
- rf_we is high only in WRITE, and only if the held in_rf_we=1 and rf_wa≠0. x0 is never written.
- Load alignment, using the low 32 bits of mem_rdata:
  - Byte lanes: byte = addr_lo*8; half = addr_lo[1]*16.
  - LB=000 and LH=001: sign-extend to XLEN.
  - LBU=100, LHU=101 and LWU=110: zero-extend.
  - LW=010: sign-extend.
  - Any other funct3 is treated as LW.
  - Misaligned halfword (addr_lo[0]=1): the half is taken at addr_lo[1]. No trap is raised.
- flush has no effect on a load already in WAIT_MEM; that load is committed.
- mem_rvalid outside WAIT_MEM is ignored. The bench flags this as a protocol error.

## Timing
- Reset (async, rstn=0): state=EMPTY, rf_we=0, rf_wa=0, rf_wd=0, load_pending=0, pend_rd=0, in_ready=1.
- Non-load latency: accepted at edge N; rf_we/rf_wa/rf_wd are valid during cycle N+1.
- Load latency: rf write occurs in the cycle after the edge that samples mem_rvalid. The minimum is 2 cycles after accept.
- Back-to-back: in WRITE, in_ready=1. A new instruction accepted in a WRITE cycle occupies the next cycle with no bubble.
- in_ready = (state≠WAIT_MEM). It is combinational from state only; it never depends on in_valid.
- load_pending and pend_rd are registered. The hazard unit uses them to stall any consumer of pend_rd.
- Reset asserted mid-WAIT_MEM: the stage returns to EMPTY immediately and the load is lost. A response arriving after release is ignored.

## Structure
- Package wb_pkg:
  - state enum {EMPTY, WRITE, WAIT_MEM};
  - funct3 load constants (LB, LH, LW, LBU, LHU, LWU);
  - writeback source index constants (ALU_RES=0, PC_ADD4=1, MEM_RD=2, IMM=3).
- Sub-module load_align: combinational; inputs mem_rdata, funct3 and addr_lo; output is the XLEN extended value.
- Top level holds the FSM, the pipeline register and the select.

## Test plan
- Reset: rstn=0 mid-WAIT_MEM → rf_we=0, in_ready=1, load_pending=0 at once. A later mem_rvalid causes no write.
- Non-load: in_sel=1, src1=0x0000_1004, rd=5, accepted at edge N → rf_we=1, rf_wa=5, rf_wd=0x0000_1004 in cycle N+1. With rd=0, rf_we stays 0.
- Load alignment: mem_rdata=0x80FF_7F01.
  - LB at offset 1 → 0x0000_007F.
  - LB at offset 3 → 0xFFFF_FF80.
  - LHU at offset 2 → 0x0000_80FF.
  - LH at offset 2 → 0xFFFF_80FF.
  - LW → 0x80FF_7F01.
- Load stall: load accepted, mem_rvalid delayed 3 cycles → in_ready=0 and load_pending=1 with pend_rd correct throughout. The write occurs in the cycle after mem_rvalid, and in_ready returns to 1 in that cycle.
- Flush/back-to-back:
  - Two consecutive non-loads → writes in consecutive cycles.
  - flush=1 with in_valid=1 → no write follows.
  - flush during WAIT_MEM → the load still writes.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage.
package wb_pkg;

    // Stage occupancy: nothing held, one-cycle write, or a load waiting on memory.
    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        WRITE    = 2'd1,
        WAIT_MEM = 2'd2
    } state_t;

    // Load size/sign encodings carried in funct3.
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

    // Writeback source indices into the packed candidate bus.
    localparam int ALU_RES = 0;
    localparam int PC_ADD4 = 1;
    localparam int MEM_RD  = 2;
    localparam int IMM     = 3;

endpackage

// File: rtl/load_align.sv
// Combinational load data aligner: picks the byte/half/word lane from the
// low 32 bits of the memory word and sign- or zero-extends it to XLEN.
module load_align
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] mem_rdata,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] data
);

    logic [31:0] word;
    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Lane extraction; a misaligned half simply uses addr_lo[1] to choose the half.
    always_comb begin
        word    = mem_rdata[31:0];
        shifted = word >> {addr_lo, 3'b000};
        byte_v  = shifted[7:0];
        half_v  = addr_lo[1] ? word[31:16] : word[15:0];
    end

    // Extension by funct3; unknown encodings behave as LW.
    always_comb begin
        data = '0;
        case (funct3)
            LB: begin
                data[7:0]      = byte_v;
                data[XLEN-1:8] = {(XLEN-8){byte_v[7]}};
            end
            LH: begin
                data[15:0]      = half_v;
                data[XLEN-1:16] = {(XLEN-16){half_v[15]}};
            end
            LBU: data[7:0]  = byte_v;
            LHU: data[15:0] = half_v;
            LWU: data[31:0] = word;
            default: begin
                data         = {XLEN{word[31]}};
                data[31:0]   = word;
            end
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB pipeline register, source select, load wait and
// alignment, registered register-file write port and hazard bypass outputs.
//
// Handshake: an instruction transfers on a rising edge where
// in_valid && in_ready && !flush; in_ready depends only on state (low in
// WAIT_MEM), and a memory response is consumed only in WAIT_MEM.
module wb_stage
    import wb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NSRC  = 4,
    parameter int SEL_W = $clog2(NSRC)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NSRC*XLEN-1:0] in_src,
    input  logic [SEL_W-1:0]     in_sel,
    input  logic [4:0]           in_rd,
    input  logic                 in_rf_we,
    input  logic                 in_is_load,
    input  logic [2:0]           in_funct3,
    input  logic [1:0]           in_addr_lo,
    input  logic                 flush,
    input  logic                 mem_rvalid,
    input  logic [XLEN-1:0]      mem_rdata,
    output logic                 rf_we,
    output logic [4:0]           rf_wa,
    output logic [XLEN-1:0]      rf_wd,
    output logic                 load_pending,
    output logic [4:0]           pend_rd,
    output state_t               dbg_state
);

    state_t          state;
    state_t          state_nx;
    logic            accept;
    logic            held_we;
    logic [2:0]      held_funct3;
    logic [1:0]      held_addr_lo;
    logic [XLEN-1:0] sel_val;
    logic [XLEN-1:0] aligned;

    assign accept    = in_valid && in_ready && !flush;
    assign dbg_state = state;

    // Source select; an index beyond the populated candidates yields zero.
    always_comb begin
        sel_val = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (in_sel == SEL_W'(k)) sel_val = in_src[k*XLEN +: XLEN];
        end
    end

    load_align #(.XLEN(XLEN)) u_align (
        .mem_rdata (mem_rdata),
        .funct3    (held_funct3),
        .addr_lo   (held_addr_lo),
        .data      (aligned)
    );

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= EMPTY;
        else       state <= state_nx;
    end

    // Next-state: a held load ignores flush and new traffic until memory answers.
    always_comb begin
        state_nx = state;
        case (state)
            WAIT_MEM: if (mem_rvalid) state_nx = WRITE;
            default: begin
                if (accept) state_nx = in_is_load ? WAIT_MEM : WRITE;
                else        state_nx = EMPTY;
            end
        endcase
    end

    // Outputs decoded from state; x0 is never written.
    always_comb begin
        in_ready = (state != WAIT_MEM);
        rf_we    = (state == WRITE) && held_we && (rf_wa != 5'd0);
    end

    // Pipeline register: capture at accept, load data lands on the response edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rf_wa        <= '0;
            rf_wd        <= '0;
            held_we      <= 1'b0;
            held_funct3  <= '0;
            held_addr_lo <= '0;
            pend_rd      <= '0;
            load_pending <= 1'b0;
        end else begin
            load_pending <= (state_nx == WAIT_MEM);
            if (accept) begin
                rf_wa        <= in_rd;
                held_we      <= in_rf_we;
                held_funct3  <= in_funct3;
                held_addr_lo <= in_addr_lo;
                if (in_is_load) pend_rd <= in_rd;
                else            rf_wd   <= sel_val;
            end else if (state == WAIT_MEM && mem_rvalid) begin
                rf_wd <= aligned;
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage with a queue-based write scoreboard.
module tb_wb_stage;
    import wb_pkg::*;

    localparam int XLEN  = 32;
    localparam int NSRC  = 4;
    localparam int SEL_W = 2;
    localparam int W     = 5 + XLEN;
    localparam logic [31:0] MEM_WORD = 32'h80FF_7F01;

    logic                 clk;
    logic                 rstn;
    logic                 in_valid;
    logic                 in_ready;
    logic [NSRC*XLEN-1:0] in_src;
    logic [SEL_W-1:0]     in_sel;
    logic [4:0]           in_rd;
    logic                 in_rf_we;
    logic                 in_is_load;
    logic [2:0]           in_funct3;
    logic [1:0]           in_addr_lo;
    logic                 flush;
    logic                 mem_rvalid;
    logic [XLEN-1:0]      mem_rdata;
    logic                 rf_we;
    logic [4:0]           rf_wa;
    logic [XLEN-1:0]      rf_wd;
    logic                 load_pending;
    logic [4:0]           pend_rd;
    state_t               dbg_state;

    logic [W-1:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;
    logic stray_ok = 1'b0;

    wb_stage #(.XLEN(XLEN), .NSRC(NSRC), .SEL_W(SEL_W)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_src       (in_src),
        .in_sel       (in_sel),
        .in_rd        (in_rd),
        .in_rf_we     (in_rf_we),
        .in_is_load   (in_is_load),
        .in_funct3    (in_funct3),
        .in_addr_lo   (in_addr_lo),
        .flush        (flush),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .rf_we        (rf_we),
        .rf_wa        (rf_wa),
        .rf_wd        (rf_wd),
        .load_pending (load_pending),
        .pend_rd      (pend_rd),
        .dbg_state    (dbg_state)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drivers.
    task automatic idle();
        in_valid = 1'b0; flush = 1'b0; in_is_load = 1'b0; in_rf_we = 1'b0;
    endtask

    task automatic issue_alu(input logic [4:0] rd, input logic [1:0] sel,
                             input logic we, input logic [31:0] exp, input logic fl);
        in_valid = 1'b1; in_is_load = 1'b0; in_rd = rd; in_sel = sel;
        in_rf_we = we; flush = fl;
        if (we && rd != 5'd0 && !fl) exp_q.push_back({rd, exp});
        @(posedge clk); #1;
        idle();
    endtask

    task automatic issue_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off);
        in_valid = 1'b1; in_is_load = 1'b1; in_rd = rd; in_rf_we = 1'b1;
        in_funct3 = f3; in_addr_lo = off; in_sel = 2'd0; flush = 1'b0;
        @(posedge clk); #1;
        idle();
    endtask

    task automatic load_resp(input logic [4:0] rd, input int delay, input logic [31:0] exp);
        exp_q.push_back({rd, exp});
        for (int i = 0; i < delay; i++) begin
            check("stall_ready", {31'd0, in_ready}, 32'd0);
            check("stall_pending", {31'd0, load_pending}, 32'd1);
            check("stall_pend_rd", {27'd0, pend_rd}, {27'd0, rd});
            @(posedge clk); #1;
        end
        mem_rvalid = 1'b1; mem_rdata = MEM_WORD;
        @(posedge clk); #1;
        mem_rvalid = 1'b0; mem_rdata = '0;
        check("resp_ready", {31'd0, in_ready}, 32'd1);
        check("resp_we", {31'd0, rf_we}, 32'd1);
    endtask

    task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off,
                           input logic [31:0] exp);
        issue_load(rd, f3, off);
        load_resp(rd, 0, exp);
    endtask

    // Scoreboard monitor: every observed write must match the oldest expectation.
    always @(negedge clk) begin
        if (rstn && rf_we) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got rd=%0d data=0x%08h expected no write", rf_wa, rf_wd);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if ({rf_wa, rf_wd} !== e) begin
                    n_fail++;
                    $display("FAIL write: got rd=%0d data=0x%08h expected rd=%0d data=0x%08h",
                             rf_wa, rf_wd, e[W-1:XLEN], e[XLEN-1:0]);
                end
            end
        end
        if (rstn && mem_rvalid && !load_pending && !stray_ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL protocol: got mem_rvalid=1 expected 0 outside a pending load");
        end
    end

    // Time bound on the whole run.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; idle();
        in_src = {32'h0000_3333, 32'h0000_2222, 32'h0000_1004, 32'h0000_0AAA};
        in_sel = '0; in_rd = '0; in_funct3 = '0; in_addr_lo = '0;
        mem_rvalid = 1'b0; mem_rdata = '0;
        #12;
        check("rst_we", {31'd0, rf_we}, 32'd0);
        check("rst_wa", {27'd0, rf_wa}, 32'd0);
        check("rst_wd", rf_wd, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_pending", {31'd0, load_pending}, 32'd0);
        check("rst_pend_rd", {27'd0, pend_rd}, 32'd0);
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;

        // Non-load select and x0 suppression.
        issue_alu(5'd5, 2'd1, 1'b1, 32'h0000_1004, 1'b0);
        check("alu_we", {31'd0, rf_we}, 32'd1);
        check("alu_wa", {27'd0, rf_wa}, 32'd5);
        check("alu_wd", rf_wd, 32'h0000_1004);
        issue_alu(5'd0, 2'd1, 1'b1, 32'h0, 1'b0);
        check("x0_we", {31'd0, rf_we}, 32'd0);
        issue_alu(5'd9, 2'd3, 1'b0, 32'h0, 1'b0);
        check("nowe_we", {31'd0, rf_we}, 32'd0);
        @(posedge clk); #1;

        // Load alignment vectors.
        do_load(5'd10, LB,  2'd1, 32'h0000_007F);
        do_load(5'd11, LB,  2'd3, 32'hFFFF_FF80);
        do_load(5'd12, LHU, 2'd2, 32'h0000_80FF);
        do_load(5'd13, LH,  2'd2, 32'hFFFF_80FF);
        do_load(5'd14, LW,  2'd0, 32'h80FF_7F01);
        do_load(5'd15, LBU, 2'd3, 32'h0000_0080);
        do_load(5'd16, LH,  2'd1, 32'h0000_7F01);
        do_load(5'd17, LH,  2'd3, 32'hFFFF_80FF);
        do_load(5'd18, 3'b111, 2'd0, 32'h80FF_7F01);
        do_load(5'd19, LWU, 2'd0, 32'h80FF_7F01);

        // Load stall of three cycles.
        issue_load(5'd20, LW, 2'd0);
        load_resp(5'd20, 3, 32'h80FF_7F01);
        @(posedge clk); #1;

        // Back-to-back non-loads, then a flushed offer.
        in_valid = 1'b1; in_is_load = 1'b0; in_rf_we = 1'b1; in_rd = 5'd6; in_sel = 2'd0;
        exp_q.push_back({5'd6, 32'h0000_0AAA});
        @(posedge clk); #1;
        check("b2b_first_we", {31'd0, rf_we}, 32'd1);
        in_rd = 5'd7; in_sel = 2'd2;
        exp_q.push_back({5'd7, 32'h0000_2222});
        @(posedge clk); #1;
        idle();
        check("b2b_second_we", {31'd0, rf_we}, 32'd1);
        check("b2b_second_wa", {27'd0, rf_wa}, 32'd7);
        issue_alu(5'd8, 2'd3, 1'b1, 32'h0, 1'b1);
        check("flush_we", {31'd0, rf_we}, 32'd0);
        check("flush_ready", {31'd0, in_ready}, 32'd1);

        // Flush and new traffic while a load waits; the load still commits.
        issue_load(5'd21, LB, 2'd3);
        in_valid = 1'b1; flush = 1'b1; in_rd = 5'd22; in_rf_we = 1'b1;
        @(posedge clk); #1;
        idle();
        load_resp(5'd21, 1, 32'hFFFF_FF80);
        @(posedge clk); #1;

        // Reset during WAIT_MEM drops the load; a late response writes nothing.
        issue_load(5'd23, LW, 2'd0);
        @(posedge clk); #1;
        check("pre_rst_pending", {31'd0, load_pending}, 32'd1);
        rstn = 1'b0; #1;
        check("midrst_we", {31'd0, rf_we}, 32'd0);
        check("midrst_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_pending", {31'd0, load_pending}, 32'd0);
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;
        stray_ok = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = MEM_WORD;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        check("stray_we", {31'd0, rf_we}, 32'd0);
        check("stray_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        stray_ok = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
